// File: rtl/ringosc_freq_counter.sv
// Ring-oscillator frequency counter: counts synchronized rising edges of osc_in
// over a selectable gate of 256/1024/4096/16384 clk cycles and holds the result.
module ringosc_freq_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             osc_in,
    input  logic             start,
    input  logic [1:0]       gate_sel,
    input  logic             byte_sel,
    output logic             busy,
    output logic             valid,
    output logic             overflow,
    output logic [CNT_W-1:0] count,
    output logic [7:0]       data_byte
);

    localparam int unsigned TMR_W = 14;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic [1:0]         sync_q;
    logic               hist_q;

    logic               edge_c;
    logic               sat_c;
    logic [CNT_W-1:0]   cnt_inc_c;
    logic               ovf_inc_c;

    // Gate length minus one, loaded into the down-counting timer.
    function automatic logic [TMR_W-1:0] gate_last(input logic [1:0] sel);
        logic [TMR_W-1:0] v;
        case (sel)
            2'd0:    v = TMR_W'(255);
            2'd1:    v = TMR_W'(1023);
            2'd2:    v = TMR_W'(4095);
            default: v = TMR_W'(16383);
        endcase
        return v;
    endfunction

    // Rising edge of the synchronized oscillator: one-cycle pulse.
    assign edge_c    = sync_q[1] & ~hist_q;
    assign sat_c     = (edge_cnt_q == {CNT_W{1'b1}});
    assign cnt_inc_c = (edge_c && !sat_c) ? edge_cnt_q + CNT_W'(1) : edge_cnt_q;
    assign ovf_inc_c = ovf_q | (edge_c & sat_c);

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        edge_cnt_d = edge_cnt_q;
        ovf_d      = ovf_q;
        count_d    = count_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (ena && start) begin
                    state_d    = S_COUNT;
                    timer_d    = gate_last(gate_sel);
                    edge_cnt_d = '0;
                    ovf_d      = 1'b0;
                end
            end
            S_COUNT: begin
                edge_cnt_d = cnt_inc_c;
                ovf_d      = ovf_inc_c;
                if (timer_q == '0) begin
                    // Final gate cycle: its edge is included in the captured total.
                    state_d = S_DONE;
                    count_d = cnt_inc_c;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Disable aborts any measurement without capturing; results hold.
        if (!ena) begin
            state_d = S_IDLE;
            count_d = count_q;
            ovf_d   = ovf_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            edge_cnt_q <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            sync_q     <= '0;
            hist_q     <= 1'b0;
            busy       <= 1'b0;
            valid      <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            edge_cnt_q <= edge_cnt_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            sync_q     <= {sync_q[0], osc_in};
            hist_q     <= sync_q[1];
            busy       <= (state_d == S_COUNT);
            valid      <= (state_d == S_DONE);
        end
    end

    assign overflow  = ovf_q;
    assign count     = count_q;
    assign data_byte = byte_sel ? 8'(count_q >> 8) : count_q[7:0];

endmodule

// File: tb/tb_ringosc_freq_counter.sv
// Scoreboard bench: a 16-bit and an 8-bit counter share stimulus; per-instance
// monitors pop expected results whenever valid rises.
module tb_ringosc_freq_counter;

    logic        clk = 1'b0;
    logic        rst_n, ena, osc_in, start, byte_sel;
    logic [1:0]  gate_sel;

    logic        busy16, valid16, ovf16;
    logic [15:0] count16;
    logic [7:0]  db16;
    logic        busy8, valid8, ovf8;
    logic [7:0]  count8;
    logic [7:0]  db8;

    always #5 clk = ~clk;

    ringosc_freq_counter #(.CNT_W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .osc_in(osc_in), .start(start),
        .gate_sel(gate_sel), .byte_sel(byte_sel), .busy(busy16), .valid(valid16),
        .overflow(ovf16), .count(count16), .data_byte(db16)
    );

    ringosc_freq_counter #(.CNT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .osc_in(osc_in), .start(start),
        .gate_sel(gate_sel), .byte_sel(byte_sel), .busy(busy8), .valid(valid8),
        .overflow(ovf8), .count(count8), .data_byte(db8)
    );

    typedef struct {
        int n;
        int cnt;
        int tol;
        bit ovf;
        bit bsel;
    } exp_t;

    exp_t q16[$];
    exp_t q8[$];
    exp_t e16, e8;
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input int act, input int exp, input int tol);
        tests++;
        if (act < exp - tol || act > exp + tol) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, exp, tol);
        end
    endtask

    task automatic judge(input string tag, input exp_t e, input int blen,
                         input int cnt, input int ovf, input int db, input int w);
        int ebyte;
        ebyte = e.bsel ? ((w > 8) ? ((e.cnt >> 8) & 255) : 0) : (e.cnt & 255);
        chk({tag, " gate_len"}, blen, e.n, 0);
        chk({tag, " count"}, cnt, e.cnt, e.tol);
        chk({tag, " overflow"}, ovf, int'(e.ovf), 0);
        chk({tag, " data_byte"}, db, ebyte, e.bsel ? 0 : e.tol);
    endtask

    // Oscillator model: period in clk cycles (0 = static level), high for period/2.
    int   osc_period = 0;
    logic osc_level  = 1'b0;
    int   ph = 0;
    initial begin
        osc_in = 1'b0;
        forever begin
            @(negedge clk);
            if (osc_period == 0) begin
                osc_in = osc_level;
                ph = 0;
            end else begin
                osc_in = (ph < osc_period / 2);
                ph = (ph + 1) % osc_period;
            end
        end
    end

    // Monitors: busy run length at the valid rise must equal the gate length.
    int   blen16 = 0, blen8 = 0;
    logic pv16 = 1'b0, pv8 = 1'b0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (valid16 && !pv16) begin
                if (q16.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL dut16 unexpected valid: got 1, expected 0");
                end else begin
                    e16 = q16.pop_front();
                    judge("dut16", e16, blen16, int'(count16), int'(ovf16), int'(db16), 16);
                end
            end
            blen16 = busy16 ? blen16 + 1 : 0;
            pv16   = valid16;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (valid8 && !pv8) begin
                if (q8.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL dut8 unexpected valid: got 1, expected 0");
                end else begin
                    e8 = q8.pop_front();
                    judge("dut8", e8, blen8, int'(count8), int'(ovf8), int'(db8), 8);
                end
            end
            blen8 = busy8 ? blen8 + 1 : 0;
            pv8   = valid8;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_valid(input int budget);
        int k;
        k = 0;
        while (!valid16 && k < budget) begin
            tick(1);
            k++;
        end
        if (!valid16) begin
            tests++; fails++;
            $display("FAIL valid timeout: got 0 after %0d cycles, expected 1", budget);
        end
    endtask

    task automatic push_exp(input int gsel, input int bsel,
                            input int c16, input int t16, input int o16,
                            input int c8, input int t8, input int o8);
        int n;
        n = 256 << (2 * gsel);
        q16.push_back('{n: n, cnt: c16, tol: t16, ovf: o16[0], bsel: bsel[0]});
        q8.push_back('{n: n, cnt: c8, tol: t8, ovf: o8[0], bsel: bsel[0]});
    endtask

    task automatic run(input int gsel, input int period, input logic level, input int bsel,
                       input int c16, input int t16, input int o16,
                       input int c8, input int t8, input int o8);
        osc_period = period;
        osc_level  = level;
        byte_sel   = bsel[0];
        tick(12);
        push_exp(gsel, bsel, c16, t16, o16, c8, t8, o8);
        gate_sel = 2'(gsel);
        start    = 1'b1;
        tick(1);
        start    = 1'b0;
        wait_valid((256 << (2 * gsel)) + 20);
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b0; start = 1'b0; byte_sel = 1'b0; gate_sel = 2'd0;
        tick(2);
        chk("reset busy", int'(busy16), 0, 0);
        chk("reset valid", int'(valid16), 0, 0);
        chk("reset overflow", int'(ovf16), 0, 0);
        chk("reset count", int'(count16), 0, 0);
        chk("reset data_byte lo", int'(db16), 0, 0);
        byte_sel = 1'b1;
        #1;
        chk("reset data_byte hi", int'(db16), 0, 0);
        chk("reset dut8 count", int'(count8), 0, 0);
        rst_n = 1'b1; ena = 1'b1;

        // Basic: period 8, 256-cycle gate, high byte selected.
        run(0, 8, 1'b0, 1, 32, 1, 0, 32, 1, 0);

        // Long gate: period 3 over 16384 cycles = 5461.33 edges; 8-bit saturates.
        run(3, 3, 1'b0, 0, 5461, 1, 0, 255, 0, 1);
        byte_sel = 1'b1;
        #1;
        chk("long data_byte hi", int'(db16), 'h15, 0);
        chk("long dut8 data_byte hi", int'(db8), 0, 0);

        // Saturation on 8-bit, then a clean run clears overflow.
        run(1, 2, 1'b0, 0, 512, 1, 0, 255, 0, 1);
        run(0, 8, 1'b0, 0, 32, 1, 0, 32, 1, 0);

        // start held and gate_sel changed during COUNT: gate stays 256.
        osc_period = 8;
        tick(12);
        push_exp(0, 0, 32, 1, 0, 32, 1, 0);
        gate_sel = 2'd0;
        start    = 1'b1;
        tick(1);
        gate_sel = 2'd3;
        wait_valid(300);
        start    = 1'b0;

        // Abort at cycle 100 of COUNT: no capture, previous result holds.
        osc_period = 3;
        tick(12);
        gate_sel = 2'd1;
        start    = 1'b1;
        tick(1);
        start    = 1'b0;
        tick(99);
        chk("abort busy before", int'(busy16), 1, 0);
        ena = 1'b0;
        tick(1);
        chk("abort busy", int'(busy16), 0, 0);
        chk("abort valid", int'(valid16), 0, 0);
        chk("abort count", int'(count16), 32, 1);
        chk("abort dut8 count", int'(count8), 32, 1);
        chk("abort dut8 overflow", int'(ovf8), 0, 0);
        tick(20);
        chk("abort stays idle", int'(valid16), 0, 0);
        ena = 1'b1;

        // Static input through a 4096-cycle gate.
        run(2, 0, 1'b1, 0, 0, 0, 0, 0, 0, 0);

        // Reset mid-COUNT aborts; the next measurement is normal.
        osc_period = 8;
        tick(12);
        gate_sel = 2'd0;
        start    = 1'b1;
        tick(1);
        start    = 1'b0;
        tick(50);
        rst_n = 1'b0;
        tick(1);
        chk("midreset busy", int'(busy16), 0, 0);
        chk("midreset valid", int'(valid16), 0, 0);
        chk("midreset count", int'(count16), 0, 0);
        rst_n = 1'b1;
        run(0, 8, 1'b0, 0, 32, 1, 0, 32, 1, 0);

        tick(5);
        chk("scoreboard drained dut16", q16.size(), 0, 0);
        chk("scoreboard drained dut8", q8.size(), 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
